// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline boundary register for the five-stage exception-capable
// core. One instance sits at each stage boundary (F/D, D/E, E/M, M/W) and
// carries the PC, instruction, exception code and branch-delay flag of the
// slot, together with a valid bit that marks real instructions versus
// bubbles.
//
// Per-cycle action priority: reset > int_req > stall > eret_flush > capture.
//   int_req    : load a bubble whose PC is HANDLER_PC (exception entry).
//   stall      : hold all data outputs.
//   eret_flush : load a bubble whose PC is epc (return from exception).
//   capture    : load the upstream slot. A real instruction keeps its
//                upstream exception if one is already recorded; otherwise
//                it picks up the exception detected at this boundary.
//
// The block also keeps observability state for the hazard unit:
//   stall_cnt    : saturating count of held cycles.
//   flush_cnt    : saturating count of loaded flush bubbles.
//   wdog_timeout : sticky flag set once WDOG_LIMIT consecutive held cycles
//                  have been seen (deadlock indication).
// clr_cnt zeroes all of the above without touching the pipeline data.
//
// Ports:
//   clk, reset                  clock (rising edge), sync active-high reset
//   stall, int_req, eret_flush  stage control from the hazard unit
//   epc                         return PC used by eret_flush
//   clr_cnt                     synchronous clear of counters and watchdog
//   in_valid/in_pc/in_instr/
//   in_exc/in_bd                upstream slot
//   local_exc                   exception found at this boundary
//                               (NONE_EXC when none)
//   out_valid/out_pc/out_instr/
//   out_exc/out_bd              registered slot
//   stall_cnt, flush_cnt        saturating performance counters
//   wdog_timeout                sticky watchdog flag
//
// All outputs come straight from flops: one cycle of latency and no
// combinational path from any input to any output.
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                PC_W       = 32,
    parameter int                INSTR_W    = 32,
    parameter int                EXC_W      = 5,
    parameter logic [PC_W-1:0]   RESET_PC   = 32'h0000_3000,
    parameter logic [PC_W-1:0]   HANDLER_PC = 32'h0000_4180,
    parameter int                NONE_EXC   = 31,
    parameter int                CNT_W      = 16,
    parameter int                WDOG_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 int_req,
    input  logic                 eret_flush,
    input  logic [PC_W-1:0]      epc,
    input  logic                 clr_cnt,
    input  logic                 in_valid,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [EXC_W-1:0]     in_exc,
    input  logic                 in_bd,
    input  logic [EXC_W-1:0]     local_exc,
    output logic                 out_valid,
    output logic [PC_W-1:0]      out_pc,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [EXC_W-1:0]     out_exc,
    output logic                 out_bd,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic                 wdog_timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               RUN_W     = $clog2(WDOG_LIMIT + 1);
    localparam logic [EXC_W-1:0] NONE_CODE = EXC_W'(NONE_EXC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(WDOG_LIMIT);
    localparam logic [RUN_W-1:0] RUN_PRE   = RUN_W'(WDOG_LIMIT - 1);

    // What the data register does on the coming edge (reset handled apart).
    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_HOLD,
        ACT_INT,
        ACT_ERET
    } stage_act_e;

    stage_act_e           act;
    logic                 held;
    logic                 flush_evt;
    logic [EXC_W-1:0]     merged_exc;
    logic [RUN_W-1:0]     run_len;

    // ------------------------------------------------------------------------
    // Action decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        act = ACT_CAPTURE;
        if (int_req) begin
            act = ACT_INT;
        end else if (stall) begin
            act = ACT_HOLD;
        end else if (eret_flush) begin
            act = ACT_ERET;
        end
    end

    // A held edge is a stall that int_req did not override; eret_flush under
    // stall is dropped (the hazard unit re-asserts it), so it is no flush.
    assign held      = (act == ACT_HOLD);
    assign flush_evt = (act == ACT_INT) || (act == ACT_ERET);

    // The older exception (already carried from upstream) wins over one
    // detected at this boundary.
    assign merged_exc = (in_exc != NONE_CODE) ? in_exc : local_exc;

    // ------------------------------------------------------------------------
    // Slot register
    // ------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= RESET_PC;
            out_instr <= '0;
            out_exc   <= NONE_CODE;
            out_bd    <= 1'b0;
        end else begin
            unique case (act)
                ACT_INT: begin
                    out_valid <= 1'b0;
                    out_pc    <= HANDLER_PC;
                    out_instr <= '0;
                    out_exc   <= NONE_CODE;
                    out_bd    <= 1'b0;
                end
                ACT_HOLD: begin
                    out_valid <= out_valid;
                    out_pc    <= out_pc;
                    out_instr <= out_instr;
                    out_exc   <= out_exc;
                    out_bd    <= out_bd;
                end
                ACT_ERET: begin
                    out_valid <= 1'b0;
                    out_pc    <= epc;
                    out_instr <= '0;
                    out_exc   <= NONE_CODE;
                    out_bd    <= 1'b0;
                end
                default: begin
                    // A bubble arriving from upstream still carries its PC
                    // so later stages can report where the slot came from.
                    out_valid <= in_valid;
                    out_pc    <= in_pc;
                    out_instr <= in_valid ? in_instr   : '0;
                    out_exc   <= in_valid ? merged_exc : NONE_CODE;
                    out_bd    <= in_valid ? in_bd      : 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters (saturating, clr_cnt beats a same-cycle event)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            stall_cnt <= '0;
        end else if (held && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            flush_cnt <= '0;
        end else if (flush_evt && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Stall watchdog
    // ------------------------------------------------------------------------
    // run_len counts consecutive held edges and parks at WDOG_LIMIT; any
    // edge that moves the slot (capture or either flush) restarts it.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            run_len <= '0;
        end else if (held) begin
            if (run_len != RUN_MAX) begin
                run_len <= run_len + 1'b1;
            end
        end else begin
            run_len <= '0;
        end
    end

    // Set on the edge where run_len reaches WDOG_LIMIT; sticky until
    // reset or clr_cnt.
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            wdog_timeout <= 1'b0;
        end else if (held && (run_len == RUN_PRE)) begin
            wdog_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg, built with CNT_W=3 and
// WDOG_LIMIT=4 so counter saturation and the watchdog are reachable in a
// few cycles. Each step drives the inputs, advances a reference model of
// the stage, pushes the expected outputs into a scoreboard queue, clocks
// once, and pops/compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int PC_W       = 32;
    localparam int INSTR_W    = 32;
    localparam int EXC_W      = 5;
    localparam int CNT_W      = 3;
    localparam int WDOG_LIMIT = 4;
    localparam logic [PC_W-1:0]  RST_PC  = 32'h0000_3000;
    localparam logic [PC_W-1:0]  HND_PC  = 32'h0000_4180;
    localparam logic [EXC_W-1:0] NONE    = 5'd31;
    localparam logic [CNT_W-1:0] CNT_TOP = 3'd7;

    logic                 clk;
    logic                 reset;
    logic                 stall;
    logic                 int_req;
    logic                 eret_flush;
    logic [PC_W-1:0]      epc;
    logic                 clr_cnt;
    logic                 in_valid;
    logic [PC_W-1:0]      in_pc;
    logic [INSTR_W-1:0]   in_instr;
    logic [EXC_W-1:0]     in_exc;
    logic                 in_bd;
    logic [EXC_W-1:0]     local_exc;
    logic                 out_valid;
    logic [PC_W-1:0]      out_pc;
    logic [INSTR_W-1:0]   out_instr;
    logic [EXC_W-1:0]     out_exc;
    logic                 out_bd;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;
    logic                 wdog_timeout;

    pipe_stage_reg #(
        .PC_W       (PC_W),
        .INSTR_W    (INSTR_W),
        .EXC_W      (EXC_W),
        .RESET_PC   (RST_PC),
        .HANDLER_PC (HND_PC),
        .NONE_EXC   (31),
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .int_req      (int_req),
        .eret_flush   (eret_flush),
        .epc          (epc),
        .clr_cnt      (clr_cnt),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_exc       (in_exc),
        .in_bd        (in_bd),
        .local_exc    (local_exc),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_exc      (out_exc),
        .out_bd       (out_bd),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .wdog_timeout (wdog_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic                valid;
        logic [PC_W-1:0]     pc;
        logic [INSTR_W-1:0]  instr;
        logic [EXC_W-1:0]    exc;
        logic                bd;
        logic [CNT_W-1:0]    scnt;
        logic [CNT_W-1:0]    fcnt;
        logic                wdog;
    } exp_t;

    exp_t q_exp[$];

    // Reference model state.
    logic                m_valid;
    logic [PC_W-1:0]     m_pc;
    logic [INSTR_W-1:0]  m_instr;
    logic [EXC_W-1:0]    m_exc;
    logic                m_bd;
    int                  m_scnt;
    int                  m_fcnt;
    int                  m_run;
    logic                m_wdog;

    int tests_run = 0;
    int tests_failed = 0;
    int step_no = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s step %0d: observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    // Advance the reference model by one edge using the current inputs.
    task automatic model_edge();
        logic held;
        if (reset) begin
            m_valid = 1'b0; m_pc = RST_PC; m_instr = '0; m_exc = NONE; m_bd = 1'b0;
            m_scnt = 0; m_fcnt = 0; m_run = 0; m_wdog = 1'b0;
            return;
        end
        held = 1'b0;
        if (int_req) begin
            m_valid = 1'b0; m_pc = HND_PC; m_instr = '0; m_exc = NONE; m_bd = 1'b0;
        end else if (stall) begin
            held = 1'b1;
        end else if (eret_flush) begin
            m_valid = 1'b0; m_pc = epc; m_instr = '0; m_exc = NONE; m_bd = 1'b0;
        end else if (in_valid) begin
            m_valid = 1'b1; m_pc = in_pc; m_instr = in_instr; m_bd = in_bd;
            m_exc = (in_exc != NONE) ? in_exc : local_exc;
        end else begin
            m_valid = 1'b0; m_pc = in_pc; m_instr = '0; m_exc = NONE; m_bd = 1'b0;
        end
        if (clr_cnt) begin
            m_scnt = 0; m_fcnt = 0; m_run = 0; m_wdog = 1'b0;
        end else begin
            if (held && m_scnt < 7) m_scnt++;
            if ((int_req || (eret_flush && !stall)) && m_fcnt < 7) m_fcnt++;
            if (held) begin
                if (m_run < WDOG_LIMIT) m_run++;
                if (m_run == WDOG_LIMIT) m_wdog = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    // One clock: model, push expectation, clock, pop and compare.
    task automatic step();
        exp_t e;
        model_edge();
        e = '{valid: m_valid, pc: m_pc, instr: m_instr, exc: m_exc, bd: m_bd,
              scnt: CNT_W'(m_scnt), fcnt: CNT_W'(m_fcnt), wdog: m_wdog};
        q_exp.push_back(e);
        @(posedge clk);
        @(negedge clk);
        step_no++;
        if (q_exp.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = q_exp.pop_front();
            check("out_valid",    64'(out_valid),    64'(e.valid));
            check("out_pc",       64'(out_pc),       64'(e.pc));
            check("out_instr",    64'(out_instr),    64'(e.instr));
            check("out_exc",      64'(out_exc),      64'(e.exc));
            check("out_bd",       64'(out_bd),       64'(e.bd));
            check("stall_cnt",    64'(stall_cnt),    64'(e.scnt));
            check("flush_cnt",    64'(flush_cnt),    64'(e.fcnt));
            check("wdog_timeout", 64'(wdog_timeout), 64'(e.wdog));
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; int_req = 1'b0; eret_flush = 1'b0;
        epc = '0; clr_cnt = 1'b0; in_valid = 1'b0; in_pc = 32'h0000_3000;
        in_instr = '0; in_exc = NONE; in_bd = 1'b0; local_exc = NONE;
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);

        // Reset for two cycles.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_pc",    64'(out_pc),       64'h3000);
        check("rst_valid", 64'(out_valid),    64'd0);
        check("rst_exc",   64'(out_exc),      64'd31);
        check("rst_wdog",  64'(wdog_timeout), 64'd0);

        // Capture: local exception is taken when upstream has none.
        in_valid = 1'b1; in_pc = 32'h0000_3004; in_instr = 32'h2401_0001;
        in_exc = NONE; local_exc = 5'd10; in_bd = 1'b1;
        step();
        check("cap_local_exc", 64'(out_exc), 64'd10);
        // Older upstream exception wins.
        in_pc = 32'h0000_3008; in_instr = 32'h2402_0002; in_exc = 5'd4; in_bd = 1'b0;
        step();
        check("cap_older_exc", 64'(out_exc), 64'd4);
        // Upstream bubble: keeps PC, clears the rest.
        in_valid = 1'b0; in_pc = 32'h0000_300c; in_instr = 32'hdead_beef;
        in_exc = 5'd7; in_bd = 1'b1;
        step();
        in_valid = 1'b1; in_exc = NONE; local_exc = NONE;
        step();

        // Stall 3 cycles, int_req on the second one.
        in_pc = 32'h0000_3010; in_instr = 32'h1111_2222;
        stall = 1'b1;
        step();
        int_req = 1'b1;
        step();
        check("int_pc",    64'(out_pc),    64'h4180);
        check("int_valid", 64'(out_valid), 64'd0);
        int_req = 1'b0;
        step();
        check("int_stall_cnt", 64'(stall_cnt), 64'd2);
        check("int_flush_cnt", 64'(flush_cnt), 64'd1);
        stall = 1'b0;

        // Clear counters on a capture edge; data still captured.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;

        // eret under stall is ignored, then taken alone.
        stall = 1'b1; eret_flush = 1'b1; epc = 32'h0000_3010;
        in_pc = 32'h0000_3020;
        step();
        stall = 1'b0;
        step();
        check("eret_pc",    64'(out_pc),    64'h3010);
        check("eret_instr", 64'(out_instr), 64'd0);
        check("eret_fcnt",  64'(flush_cnt), 64'd1);
        eret_flush = 1'b0;

        // Watchdog: 3 held, 1 capture, 4 held.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        stall = 1'b1;
        repeat (3) step();
        check("wdog_run1", 64'(wdog_timeout), 64'd0);
        stall = 1'b0;
        step();
        stall = 1'b1;
        repeat (3) step();
        check("wdog_pre", 64'(wdog_timeout), 64'd0);
        step();
        check("wdog_set", 64'(wdog_timeout), 64'd1);
        stall = 1'b0;
        step();
        check("wdog_sticky", 64'(wdog_timeout), 64'd1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("wdog_clr", 64'(wdog_timeout), 64'd0);

        // Stall counter saturation, then clr_cnt concurrent with stall.
        stall = 1'b1;
        repeat (10) step();
        check("scnt_sat", 64'(stall_cnt), 64'(CNT_TOP));
        clr_cnt = 1'b1;
        step();
        check("scnt_clr", 64'(stall_cnt), 64'd0);
        clr_cnt = 1'b0;

        // Flush counter saturation via repeated int_req.
        stall = 1'b0; int_req = 1'b1;
        repeat (9) step();
        check("fcnt_sat", 64'(flush_cnt), 64'(CNT_TOP));
        int_req = 1'b0;

        // Reset in the middle of a stall.
        stall = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_scnt", 64'(stall_cnt), 64'd0);
        check("midrst_pc",   64'(out_pc),    64'h3000);

        // Mixed random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            stall      = ($urandom_range(0, 3) == 0);
            int_req    = ($urandom_range(0, 7) == 0);
            eret_flush = ($urandom_range(0, 7) == 0);
            clr_cnt    = ($urandom_range(0, 15) == 0);
            epc        = $urandom;
            in_valid   = $urandom_range(0, 1) == 1;
            in_pc      = $urandom;
            in_instr   = $urandom;
            in_exc     = ($urandom_range(0, 1) == 1) ? NONE : EXC_W'($urandom_range(0, 30));
            local_exc  = ($urandom_range(0, 1) == 1) ? NONE : EXC_W'($urandom_range(0, 30));
            in_bd      = $urandom_range(0, 1) == 1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the five-stage exception-capable core; generalises the F/D register to any stage boundary (F/D, D/E, E/M, M/W).
- Carries PC, instruction, exception code and branch-delay flag, and adds a valid bit.
- Merges a stage-local exception into the carried code, keeping the oldest exception.
- Adds saturating stall/flush performance counters and a sticky stall watchdog for deadlock detection.

Parameters:
PC_W, 32, PC width
INSTR_W, 32, instruction width
EXC_W, 5, exception code width
RESET_PC, 32'h0000_3000, PC loaded on reset
HANDLER_PC, 32'h0000_4180, PC loaded on interrupt/exception entry
NONE_EXC, 31, "no exception" code
CNT_W, 16, performance counter width
WDOG_LIMIT, 64, consecutive held cycles before timeout (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold stage contents
int_req  in  1  interrupt/exception entry; flush to handler bubble
eret_flush  in  1  eret redirect; bubble with PC=epc
epc  in  PC_W  return PC for eret_flush
clr_cnt  in  1  synchronous clear of counters and watchdog
in_valid  in  1  upstream slot holds a real instruction
in_pc  in  PC_W  upstream PC
in_instr  in  INSTR_W  upstream instruction
in_exc  in  EXC_W  upstream exception code
in_bd  in  1  upstream branch-delay flag
local_exc  in  EXC_W  exception detected at this boundary (NONE_EXC if none)
out_valid  out  1  registered valid
out_pc  out  PC_W  registered PC
out_instr  out  INSTR_W  registered instruction
out_exc  out  EXC_W  registered exception code
out_bd  out  1  registered branch-delay flag
stall_cnt  out  CNT_W  held-cycle count, saturating
flush_cnt  out  CNT_W  accepted flush count, saturating
wdog_timeout  out  1  sticky watchdog flag

Behaviour:
- All state updates on the rising clk edge. Strict priority per cycle: reset > int_req > stall > eret_flush > capture.
- reset: out_valid=0, out_pc=RESET_PC, out_instr=0, out_exc=NONE_EXC, out_bd=0, stall_cnt=0, flush_cnt=0, run_len=0, wdog_timeout=0.
- int_req: bubble, with out_valid=0, out_pc=HANDLER_PC, out_instr=0, out_exc=NONE_EXC, out_bd=0. Overrides stall.
- stall (no int_req): all five data outputs hold their values.
- eret_flush (no stall): bubble with out_pc=epc; other fields as in the int_req bubble. When stall is also high, stall wins and eret_flush is ignored that cycle; the hazard unit re-asserts it.
- capture, in_valid=1: out_valid=1; out_pc/out_instr/out_bd take the inputs.
  - out_exc = in_exc if in_exc!=NONE_EXC, else local_exc. The older exception wins.
- capture, in_valid=0: out_valid=0, out_pc=in_pc, out_instr=0, out_exc=NONE_EXC, out_bd=0.
- Latency: one cycle from inputs to outputs. No combinational path from inputs to outputs.
- stall_cnt: +1 on each edge with stall=1, int_req=0, reset=0. Saturates at 2^CNT_W-1 (no wrap).
- flush_cnt: +1 on each edge where an int_req or eret_flush bubble is loaded. Saturates at 2^CNT_W-1.
- run_len (internal, width clog2(WDOG_LIMIT+1)):
  - +1 on each held (stall) edge, saturating at WDOG_LIMIT.
  - Cleared to 0 on any non-held edge (capture, int_req, eret_flush).
- wdog_timeout: set on the edge where run_len becomes WDOG_LIMIT. Sticky; cleared only by reset or clr_cnt.
- clr_cnt (no reset): zeroes stall_cnt, flush_cnt, run_len and wdog_timeout; pipeline data is unaffected.
  - If clr_cnt and a counting event occur in the same cycle, clr_cnt wins and the counter becomes 0.
- Reset mid-stall or mid-flush: reset values apply on that edge; no residual state.

Test Plan:
- Assert reset 2 cycles, release -> out_pc=0x3000, out_valid=0, out_exc=31, all counters 0, wdog_timeout=0.
- Capture in_pc=0x3004, in_instr=0x24010001, in_exc=31, local_exc=10, in_valid=1 -> next cycle out_exc=10, out_valid=1. Repeat with in_exc=4 -> out_exc=4.
- Stall 3 cycles with int_req pulsed on the 2nd -> int_req edge gives out_pc=0x4180, out_valid=0; stall_cnt=2; flush_cnt=1.
- stall=1 and eret_flush=1 with epc=0x3010 for 1 cycle, then eret_flush alone -> first edge holds, second edge gives out_pc=0x3010, out_instr=0, flush_cnt=1.
- WDOG_LIMIT=4: 3 held cycles, 1 capture, 4 held cycles -> wdog_timeout stays 0 through the first run and goes 1 on the 4th edge of the second run; pulse clr_cnt -> 0.
- CNT_W=3: hold stall 10 cycles -> stall_cnt stops at 7; clr_cnt concurrent with stall -> stall_cnt=0.
